packet_encode_fsm: RTL and testbench

- Transmit-side counterpart of the packet decode FSM.
- Frames a payload held in a first-word-fall-through (FWFT) payload FIFO into the 32-bit word stream the decoder expects: [RESYNC], SOP, command word, byte-swapped word count, N payload words.
- Feeds the word-to-UART serializer through a valid/ready handshake.
- Also issues standalone RESYNC words on request.

---
 rtl/packet_proto_pkg.sv | 22 ++
 rtl/packet_encode_fsm.sv | 128 ++++++++++++
 tb/tb_packet_encode_fsm.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/packet_proto_pkg.sv
// packet_proto_pkg: framing constants, FSM states and helpers shared by the packet encode and decode FSMs.
package packet_proto_pkg;

    localparam logic [31:0] PKT_RESYNC  = 32'h1EDC6F41;
    localparam logic [31:0] PKT_SOP     = 32'h741B8CD7;
    localparam int          PKT_CMD_LSB = 24;
    localparam int          PKT_CMD_MSB = 25;

    typedef enum logic [2:0] {
        sIDLE,
        sRESYNC,
        sSOP,
        sCMD,
        sNUM,
        sPAYLOAD
    } pkt_state_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/packet_encode_fsm.sv
// packet_encode_fsm: frames FWFT FIFO payload into [RESYNC] SOP CMD NUM payload words for the serializer.
// Define PACKET_ENCODE_AUTO_RESYNC_EN to precede every packet with a RESYNC word.
module packet_encode_fsm
    import packet_proto_pkg::*;
#(
    parameter logic [31:0] P_RESYNC = PKT_RESYNC,
    parameter logic [31:0] P_SOP    = PKT_SOP,
    parameter int          P_CNT_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_packet_command,
    input  logic [P_CNT_W-1:0] i_num_words,
    input  logic               i_resync_req,
    input  logic [31:0]        i_fifo_data,
    input  logic               i_fifo_empty,
    output logic               o_fifo_rd_en,
    output logic               o_tx_word_cmd,
    output logic [31:0]        o_tx_word_data,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_packet_sent,
    output logic               o_packet_aborted,
    output logic               o_start_rejected,
    output logic               o_payload_collision
);

    pkt_state_t         state_q, state_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         cmd_q, cmd_d;
    logic               pend_q, pend_d, auto_q, auto_d;
    logic               sent_d, abort_d, rej_d;
    logic               xfer;
    logic [31:0]        cmd_word;

    assign cmd_word = 32'(cmd_q) << PKT_CMD_LSB;
    assign o_busy = state_q != sIDLE;
    assign o_tx_word_cmd = (state_q == sPAYLOAD) ? !i_fifo_empty : o_busy;
    assign o_tx_word_data = (state_q == sRESYNC)  ? P_RESYNC :
                            (state_q == sSOP)     ? P_SOP :
                            (state_q == sCMD)     ? cmd_word :
                            (state_q == sNUM)     ? byte_swap32(32'(cnt_q)) :
                            (state_q == sPAYLOAD) ? i_fifo_data : '0;
    assign xfer = o_tx_word_cmd && i_tx_ready;
    assign o_fifo_rd_en = (state_q == sPAYLOAD) && xfer;
    assign o_payload_collision = o_fifo_rd_en && (i_fifo_data == P_RESYNC || i_fifo_data == P_SOP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q          <= sIDLE;
            cnt_q            <= '0;
            cmd_q            <= '0;
            pend_q           <= 1'b0;
            auto_q           <= 1'b0;
            o_packet_sent    <= 1'b0;
            o_packet_aborted <= 1'b0;
            o_start_rejected <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cmd_q            <= cmd_d;
            pend_q           <= pend_d;
            auto_q           <= auto_d;
            o_packet_sent    <= sent_d;
            o_packet_aborted <= abort_d;
            o_start_rejected <= rej_d;
        end
    end

    // A resync request during a packet is held until the current word is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        auto_d  = auto_q;
        pend_d  = pend_q || (o_busy && state_q != sRESYNC && i_resync_req);
        sent_d  = 1'b0;
        abort_d = 1'b0;
        rej_d   = i_start && o_busy;
        case (state_q)
            sIDLE: begin
                if (i_resync_req) begin
                    state_d = sRESYNC;
                    rej_d   = i_start;
                end else if (i_start && i_num_words == '0) begin
                    rej_d = 1'b1;
                end else if (i_start) begin
                    cmd_d = i_packet_command;
                    cnt_d = i_num_words;
`ifdef PACKET_ENCODE_AUTO_RESYNC_EN
                    state_d = sRESYNC;
                    auto_d  = 1'b1;
`else
                    state_d = sSOP;
`endif
                end
            end
            sRESYNC: begin
                if (xfer) begin
                    state_d = auto_q ? sSOP : sIDLE;
                    auto_d  = 1'b0;
                end
            end
            sSOP, sCMD, sNUM: begin
                if (xfer)
                    state_d = pend_d ? sRESYNC : (state_q == sSOP) ? sCMD : (state_q == sCMD) ? sNUM : sPAYLOAD;
            end
            sPAYLOAD: begin
                if (xfer)
                    cnt_d = cnt_q - 1'b1;
                if (xfer && cnt_q == P_CNT_W'(1)) begin
                    state_d = pend_d ? sRESYNC : sIDLE;
                    sent_d  = 1'b1;
                end else if (pend_d && (xfer || i_fifo_empty)) begin
                    state_d = sRESYNC;
                end
            end
            default: state_d = sIDLE;
        endcase
        // A fully sent packet followed by a pending resync is not an abort.
        if (state_d == sRESYNC && state_q != sIDLE && state_q != sRESYNC) begin
            pend_d  = 1'b0;
            abort_d = !sent_d;
        end
    end

endmodule

// File: tb/tb_packet_encode_fsm.sv
// tb_packet_encode_fsm: directed checks of framing, backpressure, resync abort, rejects and collisions.
// Honours PACKET_ENCODE_AUTO_RESYNC_EN to expect a leading RESYNC word per packet.
module tb_packet_encode_fsm;
    localparam logic [31:0] RS  = 32'h1EDC6F41;
    localparam logic [31:0] SOP = 32'h741B8CD7;
`ifdef PACKET_ENCODE_AUTO_RESYNC_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic        clk = 0, rst = 1;
    logic        start = 0, resync_req = 0, ready = 1;
    logic [1:0]  cmd = 0;
    logic [31:0] num = 0;
    logic        rd_en, valid, busy, sent, aborted, rejected, collision;
    logic [31:0] data;
    logic [31:0] mem [0:31];
    int          wr_ptr = 0, rd_ptr = 0;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic [31:0] cap [$];
    logic [31:0] exp_q [$];
    int          n_sent, n_abort, n_rej, n_coll, n_pop, cyc, xfer_cyc, sent_cyc;
    logic        hold_v = 0;
    logic [31:0] hold_d = 0;
    int          errors = 0, checks = 0;

    assign fifo_empty = rd_ptr == wr_ptr;
    assign fifo_data  = mem[rd_ptr[4:0]];

    always #5 clk = ~clk;

    packet_encode_fsm dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_packet_command(cmd), .i_num_words(num),
        .i_resync_req(resync_req), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd_en), .o_tx_word_cmd(valid), .o_tx_word_data(data), .i_tx_ready(ready),
        .o_busy(busy), .o_packet_sent(sent), .o_packet_aborted(aborted),
        .o_start_rejected(rejected), .o_payload_collision(collision)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk)
        if (rd_en) rd_ptr <= rd_ptr + 1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (hold_v) begin
                check("hold_valid", valid, 1);
                check("hold_data", data, hold_d);
            end
            hold_v <= valid && !ready;
            hold_d <= data;
            if (valid && ready) begin
                cap.push_back(data);
                xfer_cyc <= cyc;
            end
            if (rd_en) n_pop <= n_pop + 1;
            if (collision) n_coll <= n_coll + 1;
            if (rejected) n_rej <= n_rej + 1;
            if (aborted) n_abort <= n_abort + 1;
            if (sent) begin
                n_sent <= n_sent + 1;
                sent_cyc <= cyc;
            end
        end else begin
            hold_v <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[4:0]] = w;
        wr_ptr++;
    endtask

    task automatic clear();
        cap.delete();
        exp_q.delete();
        n_sent = 0; n_abort = 0; n_rej = 0; n_coll = 0; n_pop = 0;
    endtask

    task automatic header(input logic [1:0] c, input logic [31:0] n);
        if (AR == 1) exp_q.push_back(RS);
        exp_q.push_back(SOP);
        exp_q.push_back({6'b0, c, 24'b0});
        exp_q.push_back({n[7:0], n[15:8], n[23:16], n[31:24]});
    endtask

    task automatic send(input logic [1:0] c, input logic [31:0] n);
        start = 1; cmd = c; num = n;
        tick();
        start = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) tick();
        check(tag, busy, 0);
        tick();
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF, exp_q[i]);
    endtask

    initial begin
        cyc = 0; xfer_cyc = 0; sent_cyc = 0;
        clear();
        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_pulses", {sent, aborted, rejected, collision}, 0);
        tick();
        rst = 0;
        tick();

        // Basic packet, cmd=2, N=3
        clear();
        push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
        header(2'b10, 3);
        exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002); exp_q.push_back(32'hCCCC_0003);
        send(2'b10, 3);
        check("first_valid", valid, 1);
        check("first_word", data, (AR == 1) ? RS : SOP);
        wait_idle("p1_idle");
        cmp_stream("p1");
        check("p1_sent", n_sent, 1);
        check("p1_pops", n_pop, 3);
        check("p1_sent_lat", sent_cyc - xfer_cyc, 1);

        // Backpressure and FIFO underrun, N=5
        clear();
        push(32'h0000_1111); push(32'h0000_2222);
        header(2'b01, 5);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h0000_1111 * (i + 1));
        send(2'b01, 5);
        for (int i = 0; i < 25; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        push(32'h0000_3333); push(32'h0000_4444); push(32'h0000_5555);
        for (int i = 0; i < 300 && busy; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1;
        wait_idle("bp_idle");
        cmp_stream("bp");
        check("bp_pops", n_pop, 5);
        check("bp_fifo_level", wr_ptr - rd_ptr, 0);
        check("bp_sent", n_sent, 1);

        // Resync during the 2nd of 4 payload words
        clear();
        push(32'h5000_0000); push(32'h5000_0001); push(32'h5000_0002); push(32'h5000_0003);
        header(2'b11, 4);
        exp_q.push_back(32'h5000_0000); exp_q.push_back(32'h5000_0001); exp_q.push_back(RS);
        send(2'b11, 4);
        for (int i = 0; i < 4 + AR; i++) tick();
        check("ab_w1_valid", data, 32'h5000_0001);
        resync_req = 1;
        tick();
        resync_req = 0;
        wait_idle("ab_idle");
        cmp_stream("ab");
        check("ab_aborted", n_abort, 1);
        check("ab_sent", n_sent, 0);
        check("ab_fifo_level", wr_ptr - rd_ptr, 2);

        // Zero-length start
        clear();
        send(2'b01, 0);
        tick();
        check("z_rej", n_rej, 1);
        check("z_busy", busy, 0);
        check("z_stream", cap.size(), 0);

        // Leftover payload plus a RESYNC-valued word; a start while busy is dropped
        clear();
        push(RS);
        header(2'b01, 3);
        exp_q.push_back(32'h5000_0002); exp_q.push_back(32'h5000_0003); exp_q.push_back(RS);
        send(2'b01, 3);
        tick();
        send(2'b10, 1);
        wait_idle("c_idle");
        cmp_stream("c");
        check("c_rej", n_rej, 1);
        check("c_coll", n_coll, 1);
        check("c_sent", n_sent, 1);

        // Start and resync together in idle: resync wins
        clear();
        exp_q.push_back(RS);
        resync_req = 1;
        send(2'b10, 2);
        resync_req = 0;
        wait_idle("sr_idle");
        cmp_stream("sr");
        check("sr_rej", n_rej, 1);

        // Asynchronous reset mid-packet
        clear();
        send(2'b10, 2);
        tick();
        #2 rst = 1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_valid", valid, 0);
        tick();
        rst = 0;
        tick(); tick();
        check("ar_pulses", n_sent + n_abort, 0);
        check("ar_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
